// File: rtl/data_mem_responder.sv
// Word-organised data memory answering load/store requests over valid/ready.
// Adds WAIT_CYCLES wait states; define MEM_MISALIGN_CHECK_EN to fault addr[1:0]!=0.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0] LAST =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]  cnt;
    logic        q_we;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [3:0]  q_be;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic          c_err;
    logic [AW-1:0] c_idx;

    // Next-state logic; commit marks the edge that enters RESP.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Committing request: live inputs when zero wait states, else the captured copy.
    always_comb begin
        c_we    = q_we;
        c_addr  = q_addr;
        c_wdata = q_wdata;
        c_be    = q_be;
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
        c_err = ({1'b0, c_addr} >= LIMIT);
`ifdef MEM_MISALIGN_CHECK_EN
        c_err = c_err | (c_addr[1:0] != 2'b00);
`endif
        c_idx = c_addr[AW+1:2];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Wait-state counter, cleared whenever not counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (state == WAIT && state_nx == WAIT) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_we    <= 1'b0;
            q_addr  <= 32'd0;
            q_wdata <= 32'd0;
            q_be    <= 4'd0;
        end else if (accept) begin
            q_we    <= req_we;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
            q_be    <= req_be;
        end
    end

    // Response data/status: loaded entering RESP, cleared when it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= c_err;
            rdata_q <= (c_we || c_err) ? 32'd0 : mem[c_idx];
        end else if (state == RESP && rsp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    // Byte-enabled store on the commit edge; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
